// File: rtl/spec_rx_fifo.sv
// Speculative receive FIFO: words are written speculatively by the UART receiver and
// become visible to the reader only after a commit; a rollback discards them.
module spec_rx_fifo #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 4
) (
    input  logic              CLK288MHZ,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              writeEn,
    input  logic              commitWrite,
    input  logic              rollbackWrite,
    input  logic              rdEn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              pending,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_PTR = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wrPtr;
    logic [ADDR_W:0]   r_cmPtr;
    logic [ADDR_W:0]   r_rdPtr;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_dataValid;
    logic              r_overflow;

    logic              w_empty;
    logic              w_full;
    logic [ADDR_W:0]   w_used;
    logic              w_wrAccept;
    logic              w_rdAccept;
    logic [ADDR_W:0]   w_wrPtrNext;

    assign w_used      = r_wrPtr - r_rdPtr;
    assign w_empty     = (r_rdPtr == r_cmPtr);
    assign w_full      = (w_used == DEPTH_PTR);
    assign w_wrAccept  = writeEn && !w_full && !rollbackWrite;
    assign w_rdAccept  = rdEn && !w_empty;
    // Commit must cover a write accepted in the same cycle, so it targets the next wrPtr.
    assign w_wrPtrNext = w_wrAccept ? (r_wrPtr + 1'b1) : r_wrPtr;

    always_ff @(posedge CLK288MHZ) begin
        if (!reset && w_wrAccept) begin
            r_mem[r_wrPtr[ADDR_W-1:0]] <= dataIn;
        end
    end

    always_ff @(posedge CLK288MHZ) begin
        if (reset) begin
            r_wrPtr     <= '0;
            r_cmPtr     <= '0;
            r_rdPtr     <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Rollback outranks both the write and the commit issued alongside it.
            if (rollbackWrite) begin
                r_wrPtr <= r_cmPtr;
            end else begin
                r_wrPtr <= w_wrPtrNext;
                if (commitWrite) begin
                    r_cmPtr <= w_wrPtrNext;
                end
            end

            if (writeEn && w_full && !rollbackWrite) begin
                r_overflow <= 1'b1;
            end

            r_dataValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_dataOut <= r_mem[r_rdPtr[ADDR_W-1:0]];
                r_rdPtr   <= r_rdPtr + 1'b1;
            end
        end
    end

    assign dataOut   = r_dataOut;
    assign dataValid = r_dataValid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_cmPtr - r_rdPtr;
    assign pending   = (r_wrPtr != r_cmPtr);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_spec_rx_fifo.sv
// Scoreboard bench for spec_rx_fifo: reads push expected words, a monitor pops them
// whenever dataValid is seen; flag state is checked directly after each step.
module tb_spec_rx_fifo;

    localparam int DATA_W = 9;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] dataIn;
    logic              writeEn;
    logic              commitWrite;
    logic              rollbackWrite;
    logic              rdEn;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              pending;
    logic              overflow;

    int checkCount = 0;
    int passCount  = 0;
    logic [DATA_W-1:0] expQ[$];

    spec_rx_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK288MHZ    (clk),
        .reset        (reset),
        .dataIn       (dataIn),
        .writeEn      (writeEn),
        .commitWrite  (commitWrite),
        .rollbackWrite(rollbackWrite),
        .rdEn         (rdEn),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .pending      (pending),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic we, input logic [DATA_W-1:0] d,
                                 input logic cm, input logic rb, input logic rd,
                                 input logic rst);
        writeEn       = we;
        dataIn        = d;
        commitWrite   = cm;
        rollbackWrite = rb;
        rdEn          = rd;
        reset         = rst;
        @(posedge clk);
        #1;
        writeEn       = 1'b0;
        commitWrite   = 1'b0;
        rollbackWrite = 1'b0;
        rdEn          = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic readExpect(input logic [DATA_W-1:0] exp);
        expQ.push_back(exp);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every presented word against the scoreboard head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dataValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_dataValid", 32'(dataOut), 32'h3FF);
                end else begin
                    checkOutput("read_data", 32'(dataOut), 32'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        writeEn = 0; dataIn = '0; commitWrite = 0; rollbackWrite = 0; rdEn = 0; reset = 1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_dataValid", 32'(dataValid), 32'd0);
        checkOutput("rst_dataOut", 32'(dataOut), 32'd0);

        // Single word, commit four cycles later, then read it back.
        applyStimulus(1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_pending", 32'(pending), 32'd1);
        checkOutput("t1_empty_spec", 32'(empty), 32'd1);
        idle(3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_empty_commit", 32'(empty), 32'd0);
        checkOutput("t1_count", 32'(count), 32'd1);
        checkOutput("t1_pending_clr", 32'(pending), 32'd0);
        readExpect(9'h0A5);
        checkOutput("t1_empty_after_rd", 32'(empty), 32'd1);

        // Rollback discards the speculative word; the slot is reused.
        applyStimulus(1'b1, 9'h13C, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_pending", 32'(pending), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_pending_clr", 32'(pending), 32'd0);
        checkOutput("t2_empty", 32'(empty), 32'd1);
        checkOutput("t2_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        readExpect(9'h055);

        // Fill to capacity, overflow on the 17th word, drain in order.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 9'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("t3_full", 32'(full), 32'd1);
        checkOutput("t3_count16", 32'(count), 32'd16);
        checkOutput("t3_no_overflow_yet", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        checkOutput("t3_pending_dropped", 32'(pending), 32'd0);
        checkOutput("t3_still_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) readExpect(9'(i));
        checkOutput("t3_empty", 32'(empty), 32'd1);
        checkOutput("t3_count0", 32'(count), 32'd0);
        checkOutput("t3_full_clr", 32'(full), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_rd_empty_valid", 32'(dataValid), 32'd0);
        checkOutput("t3_rd_empty_hold", 32'(dataOut), 32'h00F);
        checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Pointer wrap with one word in flight at a time.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 9'(9'h080 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("t4_count", 32'(count), 32'd1);
            checkOutput("t4_full", 32'(full), 32'd0);
            readExpect(9'(9'h080 + i));
        end

        // Same-cycle interactions between write, commit and rollback.
        applyStimulus(1'b1, 9'h0F0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_wr_commit_count", 32'(count), 32'd1);
        checkOutput("t5_wr_commit_pending", 32'(pending), 32'd0);
        applyStimulus(1'b1, 9'h1AA, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_wr_rb_pending", 32'(pending), 32'd0);
        checkOutput("t5_wr_rb_count", 32'(count), 32'd1);
        applyStimulus(1'b1, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_spec_pending", 32'(pending), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_cm_rb_count", 32'(count), 32'd1);
        checkOutput("t5_cm_rb_pending", 32'(pending), 32'd0);
        readExpect(9'h0F0);
        checkOutput("t5_empty", 32'(empty), 32'd1);

        // Reset mid-stream with a read request pending.
        applyStimulus(1'b1, 9'h0C3, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h003, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_pending", 32'(pending), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("t6_dataValid", 32'(dataValid), 32'd0);
        checkOutput("t6_dataOut", 32'(dataOut), 32'd0);
        checkOutput("t6_empty", 32'(empty), 32'd1);
        checkOutput("t6_full", 32'(full), 32'd0);
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_pending", 32'(pending), 32'd0);
        checkOutput("t6_overflow", 32'(overflow), 32'd0);
        idle(2);
        checkOutput("t6_no_late_valid", 32'(dataValid), 32'd0);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spec_rx_fifo.md
Name: spec_rx_fifo

Overview:
Speculative receive FIFO that sits directly downstream of the UART receiver, on the same 288 MHz clock.
- The receiver writes each 9-bit word (bit 8 = parity-error flag, bits 7:0 = data) as soon as its last data/parity bit is sampled.
- The receiver later commits or rolls back that word depending on the stop bit.
- Only committed words are visible to the read side, so framing-error bytes never reach the consumer.

Parameters:
DATA_W, 9, word width (bit DATA_W-1 carries the parity-error flag)
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W = 16 entries

Ports:
CLK288MHZ  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
dataIn  input  DATA_W  word from receiver
writeEn  input  1  single-cycle speculative write strobe
commitWrite  input  1  single-cycle strobe: make all speculative entries visible
rollbackWrite  input  1  single-cycle strobe: discard all speculative entries
rdEn  input  1  read request from consumer
dataOut  output  DATA_W  read data, registered
dataValid  output  1  one-cycle pulse; dataOut holds the word read
empty  output  1  no committed entries
full  output  1  storage holds DEPTH entries (committed + speculative)
count  output  ADDR_W+1  number of committed, unread entries
pending  output  1  at least one speculative entry outstanding
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Storage: DEPTH x DATA_W register array, no reset on contents.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - wrPtr: speculative write pointer.
  - cmPtr: committed pointer.
  - rdPtr: read pointer.
- All pointer arithmetic is modulo 2**(ADDR_W+1).
- Derived, combinational from registered pointers:
  - empty = (rdPtr == cmPtr).
  - full = (wrPtr - rdPtr == DEPTH).
  - count = cmPtr - rdPtr.
  - pending = (wrPtr != cmPtr).
- Speculative write: writeEn && !full && !rollbackWrite.
  - mem[wrPtr[ADDR_W-1:0]] <= dataIn; wrPtr <= wrPtr+1.
- Write while full: word dropped, wrPtr unchanged, overflow <= 1. Overflow clears only on reset.
- Commit: commitWrite && !rollbackWrite → cmPtr <= next value of wrPtr, which includes a write accepted in the same cycle.
- Rollback: rollbackWrite → wrPtr <= cmPtr. Any write in the same cycle is discarded and cmPtr is unchanged. Rollback has priority over commit and write.
- Commit or rollback with nothing pending: no pointer change, no error.
- Multiple speculative entries may accumulate before a commit or rollback; the strobe applies to all of them.
- Read: rdEn && !empty → dataOut <= mem[rdPtr], rdPtr <= rdPtr+1, dataValid <= 1 on the next cycle (latency 1).
- rdEn while empty: ignored; dataValid 0, dataOut holds its previous value.
- Read and commit in the same cycle: empty uses the pre-commit cmPtr, so a newly committed word is readable from the following cycle. count and empty update one cycle after the commit strobe.
- Read of the last committed entry while speculative entries exist: allowed. full is relieved by reads and by rollback.
- Parity flag (bit DATA_W-1) is stored and returned unmodified; the FIFO takes no action on it.
- Reset, including mid-operation:
  - wrPtr, cmPtr and rdPtr return to 0; pending speculative data is lost.
  - dataOut = 0, dataValid = 0, overflow = 0.
  - Hence empty = 1, full = 0, count = 0, pending = 0.
  - Strobes asserted during reset are ignored.

Test Plan:
- Write 0x0A5 → 4 cycles later commitWrite → empty falls the cycle after commit; count = 1. rdEn → next cycle dataValid = 1, dataOut = 0x0A5, empty = 1.
- Write 0x13C then rollbackWrite → pending 1→0, empty stays 1, count = 0. A subsequent write+commit of 0x055 reads back 0x055 (slot reused).
- 16 write/commit pairs (0x000..0x00F) → full = 1, count = 16. 17th write 0x1FF → dropped, overflow = 1, wrPtr unchanged. Reading all 16 returns 0x000..0x00F in order; empty = 1.
- 20 write/commit/read cycles to exercise pointer wrap → data order preserved, count never exceeds 1, full never asserts.
- writeEn with commitWrite in the same cycle (0x0F0) → word committed, count = 1. writeEn with rollbackWrite in the same cycle → word discarded. commitWrite and rollbackWrite together → rollback wins, count unchanged.
- Three speculative writes, then reset mid-stream with rdEn high → all outputs at reset values the next cycle; no dataValid pulse.
